// File: rtl/msfsm_fire_scheduler.sv
// Purpose : MSFSM transition scheduler. Combines per-FSM votes over participants,
//           applies inhibits, grants one transition per slot round-robin, then settles.
// Latency : fire asserts 2 cycles after run is sampled in IDLE; one firing every SETTLE+2 cycles.
// Backpressure: none. run is a level enable, and an in-flight fire/settle always completes.
// Ports   : clk/reset (async, active-low); run; en_votes[f*N_TRANS+t]; inhibit[t];
//           fire (registered one-hot pulse); busy (not IDLE); deadlock; fire_count (wraps);
//           last_fire (index of the most recent grant).
module msfsm_fire_scheduler #(
  parameter int N_FSM = 3,
  parameter int N_TRANS = 9,
  parameter logic [N_FSM*N_TRANS-1:0] PART_MASK = '1,
  parameter int SETTLE = 1,
  parameter int DEADLOCK_LIMIT = 16,
  parameter int CNT_W = 16,
  localparam int LF_W = (N_TRANS > 1) ? $clog2(N_TRANS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [N_FSM*N_TRANS-1:0] en_votes,
  input  logic [N_TRANS-1:0]       inhibit,
  output logic [N_TRANS-1:0]       fire,
  output logic                     busy,
  output logic                     deadlock,
  output logic [CNT_W-1:0]         fire_count,
  output logic [LF_W-1:0]          last_fire
);

  localparam int IC_W = $clog2(DEADLOCK_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_FIRE   = 3'd2,
    S_SETTLE = 3'd3,
    S_DEAD   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [N_TRANS-1:0] fire_q, fire_d;
  logic               deadlock_q, deadlock_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LF_W-1:0]    last_q, last_d;
  logic [LF_W-1:0]    rr_q, rr_d;
  logic [IC_W-1:0]    idle_q, idle_d;
  logic [3:0]         settle_q, settle_d;

  // Global enable: every participant must vote; a transition with no
  // participants is never enabled.
  logic [N_TRANS-1:0] all_ok;
  logic [N_TRANS-1:0] has_part;
  logic [N_TRANS-1:0] en;

  always_comb begin
    all_ok   = '1;
    has_part = '0;
    for (int t = 0; t < N_TRANS; t++) begin
      for (int f = 0; f < N_FSM; f++) begin
        if (PART_MASK[f*N_TRANS+t]) begin
          has_part[t] = 1'b1;
          if (!en_votes[f*N_TRANS+t]) all_ok[t] = 1'b0;
        end
      end
    end
    en = all_ok & has_part & ~inhibit;
  end

  // Round-robin: first enabled index strictly after the last grant, with wrap.
  logic [LF_W-1:0] grant;
  logic            grant_vld;
  int              idx;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N_TRANS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N_TRANS) idx = idx - N_TRANS;
      if (!grant_vld && en[LF_W'(idx)]) begin
        grant     = LF_W'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    fire_d     = fire_q;
    deadlock_d = deadlock_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    rr_d       = rr_q;
    idle_d     = idle_q;
    settle_d   = settle_q;
    case (state_q)
      S_IDLE: begin
        fire_d = '0;
        if (run) state_d = S_ARB;
      end
      S_ARB: begin
        if (!run) begin
          state_d = S_IDLE;
          idle_d  = '0;
        end else if (grant_vld) begin
          fire_d  = N_TRANS'(1) << grant;
          last_d  = grant;
          rr_d    = grant;
          idle_d  = '0;
          state_d = S_FIRE;
        end else begin
          idle_d = idle_q + 1'b1;
          if (idle_d == IC_W'(DEADLOCK_LIMIT)) begin
            state_d    = S_DEAD;
            deadlock_d = 1'b1;
            idle_d     = '0;  // a fresh count starts once DEAD is left
          end
        end
      end
      S_FIRE: begin
        // The counter only advances once the fire cycle completes, so a
        // reset landing mid-fire never counts that firing.
        cnt_d  = cnt_q + 1'b1;
        fire_d = '0;
        if (SETTLE > 0) begin
          settle_d = 4'(SETTLE);
          state_d  = S_SETTLE;
        end else begin
          state_d = run ? S_ARB : S_IDLE;
        end
      end
      S_SETTLE: begin
        fire_d   = '0;
        settle_d = settle_q - 1'b1;
        if (settle_q == 4'd1) state_d = run ? S_ARB : S_IDLE;
      end
      S_DEAD: begin
        deadlock_d = 1'b1;
        if (!run) begin
          state_d    = S_IDLE;
          deadlock_d = 1'b0;
        end else if (grant_vld) begin
          // Leave via ARB so the grant is re-evaluated on fresh inputs.
          state_d    = S_ARB;
          deadlock_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fire_q     <= '0;
      deadlock_q <= 1'b0;
      cnt_q      <= '0;
      last_q     <= '0;
      rr_q       <= LF_W'(N_TRANS - 1);
      idle_q     <= '0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      fire_q     <= fire_d;
      deadlock_q <= deadlock_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      rr_q       <= rr_d;
      idle_q     <= idle_d;
      settle_q   <= settle_d;
    end
  end

  assign fire       = fire_q;
  assign busy       = (state_q != S_IDLE);
  assign deadlock   = deadlock_q;
  assign fire_count = cnt_q;
  assign last_fire  = last_q;

endmodule

// File: tb/tb_msfsm_fire_scheduler.sv
// Purpose : self-checking bench for msfsm_fire_scheduler with a window-based reference model.
// Latency : model tracks fire/settle windows as a countdown, checked every cycle on negedge.
// Backpressure: not applicable; directed stimulus drives run/votes/inhibit.
module tb_msfsm_fire_scheduler;

  localparam int NF  = 3;
  localparam int NT  = 9;
  localparam int SET = 1;
  localparam int DL  = 16;
  localparam int CW  = 16;
  // FSM0 does not participate in t6.
  localparam logic [NF*NT-1:0] PM = ~(27'd1 << 6);

  logic            clk = 1'b0;
  logic            reset;
  logic            run;
  logic [NF*NT-1:0] en_votes;
  logic [NT-1:0]   inhibit;
  logic [NT-1:0]   fire;
  logic            busy;
  logic            deadlock;
  logic [CW-1:0]   fire_count;
  logic [3:0]      last_fire;

  msfsm_fire_scheduler #(
    .N_FSM(NF), .N_TRANS(NT), .PART_MASK(PM), .SETTLE(SET),
    .DEADLOCK_LIMIT(DL), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .en_votes(en_votes), .inhibit(inhibit),
    .fire(fire), .busy(busy), .deadlock(deadlock), .fire_count(fire_count),
    .last_fire(last_fire)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_busy = 0;
  bit            m_dead = 0;
  int            m_hold = 0;   // cycles left in the current fire+settle window
  int            m_idle = 0;
  int            m_ptr  = NT - 1;
  int            m_cnt  = 0;
  int            m_last = 0;
  logic [NT-1:0] m_fire = '0;

  function automatic logic [NT-1:0] model_en(input logic [NF*NT-1:0] v, input logic [NT-1:0] inh);
    logic [NT-1:0] r;
    int p, ok;
    r = '0;
    for (int t = 0; t < NT; t++) begin
      p = 0;
      ok = 0;
      for (int f = 0; f < NF; f++) begin
        if (PM[f*NT+t]) begin
          p++;
          if (v[f*NT+t]) ok++;
        end
      end
      if (p > 0 && ok == p && !inh[t]) r[t] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_dead = 0; m_hold = 0; m_idle = 0;
    m_ptr = NT - 1; m_cnt = 0; m_last = 0; m_fire = '0;
  endtask

  task automatic model_edge();
    logic [NT-1:0] e;
    bit found;
    int j;
    e = model_en(en_votes, inhibit);
    if (m_hold > 0) begin
      if (m_hold == SET + 1) m_cnt = (m_cnt + 1) % (1 << CW);
      m_fire = '0;
      m_hold--;
      if (m_hold == 0) m_busy = run;
    end else if (!m_busy) begin
      m_busy = run;
    end else if (!run) begin
      m_busy = 0; m_dead = 0; m_idle = 0;
    end else if (m_dead) begin
      if (e != '0) m_dead = 0;
    end else if (e != '0) begin
      found = 0;
      for (int k = 1; k <= NT; k++) begin
        j = (m_ptr + k) % NT;
        if (!found && e[4'(j)]) begin
          found = 1;
          m_fire = '0;
          m_fire[4'(j)] = 1'b1;
          m_last = j;
          m_ptr = j;
        end
      end
      m_idle = 0;
      m_hold = SET + 1;
    end else begin
      m_idle++;
      if (m_idle == DL) begin
        m_dead = 1;
        m_idle = 0;
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_edge();
  end

  // ---------------- per-cycle compare ----------------
  logic [NT-1:0] prev_fire = '0;
  always @(negedge clk) begin
    chk("fire", fire, m_fire);
    chk("busy", busy, m_busy);
    chk("deadlock", deadlock, m_dead);
    chk("fire_count", fire_count, m_cnt[CW-1:0]);
    chk("last_fire", last_fire, m_last);
    chk("fire_onehot0", $onehot0(fire), 1);
    chk("no_back_to_back", (prev_fire != '0 && fire != '0), 0);
    prev_fire = fire;
  end

  // ---------------- stimulus helpers ----------------
  task automatic to_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    to_cyc(c);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    to_cyc(cyc + 1);
    reset = 0; run = 0; en_votes = '0; inhibit = '0;
    to_cyc(cyc + 1);
    reset = 1;
  endtask

  function automatic logic [NF*NT-1:0] vote_all(input int t);
    logic [NF*NT-1:0] v;
    v = '0;
    for (int f = 0; f < NF; f++) v[f*NT+t] = 1'b1;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int c0;
  int ord[5] = '{1, 5, 7, 1, 5};

  initial begin
    reset = 0; run = 0; en_votes = '0; inhibit = '0;
    // Reset held 3 cycles with random inputs.
    repeat (3) begin
      run = 1'($urandom_range(0, 1));
      en_votes = 27'($urandom);
      inhibit = 9'($urandom);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("rst_fire", fire, 0);
    chk("rst_busy", busy, 0);
    chk("rst_deadlock", deadlock, 0);
    chk("rst_count", fire_count, 0);
    chk("rst_last", last_fire, 0);
    to_cyc(cyc + 1);
    reset = 1; run = 1; en_votes = '0; inhibit = '0;
    c0 = cyc;
    at_neg(c0 + 2);
    chk("post_rst_busy", busy, 1);
    chk("post_rst_fire", fire, 0);
    to_cyc(c0 + 3);
    run = 0;

    // Single firing of t3.
    reset_pulse();
    to_cyc(cyc + 1);
    c0 = cyc;
    en_votes = vote_all(3);
    run = 1;
    at_neg(c0 + 2);
    chk("single_fire", fire, 9'h008);
    chk("single_last", last_fire, 3);
    at_neg(c0 + 3);
    chk("single_drop", fire, 0);
    chk("single_count", fire_count, 1);
    at_neg(c0 + 5);
    chk("single_refire", fire, 9'h008);
    to_cyc(c0 + 6);
    run = 0;
    at_neg(c0 + 8);
    chk("single_idle", busy, 0);
    chk("single_count2", fire_count, 2);

    // Round-robin over t1, t5, t7.
    reset_pulse();
    to_cyc(cyc + 1);
    c0 = cyc;
    en_votes = vote_all(1) | vote_all(5) | vote_all(7);
    run = 1;
    for (int k = 0; k < 5; k++) begin
      at_neg(c0 + 2 + 3 * k);
      chk("rr_order", fire, 9'd1 << ord[k]);
    end
    to_cyc(c0 + 15);
    run = 0;
    at_neg(c0 + 16);
    chk("rr_count", fire_count, 5);

    // Participation: t6 ignores FSM0; t0 needs all three.
    reset_pulse();
    to_cyc(cyc + 1);
    c0 = cyc;
    en_votes = (27'd1 << 15) | (27'd1 << 24) | (27'd1 << 0) | (27'd1 << 9);
    run = 1;
    at_neg(c0 + 2);
    chk("part_t6", fire, 9'h040);
    at_neg(c0 + 5);
    chk("part_t6_again", fire, 9'h040);
    to_cyc(c0 + 6);
    en_votes = en_votes | (27'd1 << 18);
    at_neg(c0 + 8);
    chk("part_t0", fire, 9'h001);
    chk("part_t0_last", last_fire, 0);
    to_cyc(c0 + 9);
    run = 0;

    // Deadlock and recovery.
    reset_pulse();
    to_cyc(cyc + 1);
    c0 = cyc;
    run = 1;
    at_neg(c0 + 16);
    chk("dl_not_yet", deadlock, 0);
    at_neg(c0 + 17);
    chk("dl_set", deadlock, 1);
    at_neg(c0 + 20);
    chk("dl_hold", deadlock, 1);
    to_cyc(c0 + 21);
    en_votes = vote_all(2);
    at_neg(c0 + 22);
    chk("dl_clear", deadlock, 0);
    at_neg(c0 + 23);
    chk("dl_fire", fire, 9'h004);
    to_cyc(c0 + 24);
    run = 0;

    // Abort during settle, then inhibit.
    reset_pulse();
    to_cyc(cyc + 1);
    c0 = cyc;
    en_votes = vote_all(4);
    run = 1;
    at_neg(c0 + 2);
    chk("ab_fire", fire, 9'h010);
    to_cyc(c0 + 3);
    run = 0;
    at_neg(c0 + 3);
    chk("ab_settle_busy", busy, 1);
    at_neg(c0 + 4);
    chk("ab_idle", busy, 0);
    at_neg(c0 + 6);
    chk("ab_no_fire", fire, 0);
    chk("ab_count", fire_count, 1);
    to_cyc(c0 + 8);
    inhibit = 9'h010;
    run = 1;
    at_neg(c0 + 12);
    chk("inh_no_fire", fire, 0);
    chk("inh_busy", busy, 1);
    to_cyc(c0 + 13);
    inhibit = '0;
    at_neg(c0 + 14);
    chk("inh_release_fire", fire, 9'h010);
    to_cyc(c0 + 15);
    run = 0;

    // Reset landing mid-fire.
    to_cyc(c0 + 18);
    c0 = cyc;
    run = 1;
    to_cyc(c0 + 2);
    chk("mid_fire_pre", fire, 9'h010);
    reset = 0;
    #1;
    chk("mid_fire_async_drop", fire, 0);
    at_neg(c0 + 3);
    chk("mid_fire_count", fire_count, 0);
    to_cyc(c0 + 4);
    reset = 1;
    run = 0;
    at_neg(c0 + 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msfsm_fire_scheduler.md
Name: msfsm_fire_scheduler

Overview:
- Central transition scheduler for a synchronous multiple-state-FSM (MSFSM) array.
- Each component FSM votes on which shared internal transitions (t0..tN) it has enabled.
- The block combines the votes over each transition's participating FSMs, applies environment inhibits, and picks one globally enabled transition per firing slot with a round-robin arbiter.
- It drives that transition's one-hot fire pulse into every FSM, then waits a settle interval for state-sync outputs to update. It also detects deadlock.

Parameters:
- N_FSM, 3, number of component FSMs.
- N_TRANS, 9, number of internal transitions.
- PART_MASK, all ones (N_FSM*N_TRANS bits), bit f*N_TRANS+t = 1 when FSM f participates in transition t.
- SETTLE, 1, idle cycles after each firing (0..15).
- DEADLOCK_LIMIT, 16, consecutive empty arbitration cycles before deadlock is flagged (>=1).
- CNT_W, 16, fire counter width.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous active-low reset.
- run, input, 1, level enable for scheduling.
- en_votes, input, N_FSM*N_TRANS, bit f*N_TRANS+t = FSM f has transition t enabled.
- inhibit, input, N_TRANS, per-transition environment block.
- fire, output, N_TRANS, registered one-hot fire pulse.
- busy, output, 1, high in any state other than IDLE.
- deadlock, output, 1, deadlock flag.
- fire_count, output, CNT_W, number of firings since reset; wraps.
- last_fire, output, clog2(N_TRANS), index of the most recent firing.

Behaviour:
- Single clock domain. reset is asynchronous and active-low.
- On reset, immediately: state=IDLE, fire=0, busy=0, deadlock=0, fire_count=0, last_fire=0, rr pointer=N_TRANS-1 (first search starts at t0), idle_cnt=0, settle_cnt=0.
- Global enable: en[t] = (AND over f of (en_votes[f,t] | ~PART_MASK[f,t])) & (OR over f of PART_MASK[f,t]) & ~inhibit[t]. Votes from non-participating FSMs are ignored. A transition with no participants never fires. Inputs are sampled in ARB only.
- IDLE: fire=0. If run=1, go to ARB.
- ARB:
  - If run=0, go to IDLE and clear idle_cnt.
  - Else if any en[t], the grant is the first enabled index searching upward from pointer+1 with wrap. Register fire=onehot(grant), last_fire=grant, pointer=grant, clear idle_cnt, go to FIRE.
  - Else increment idle_cnt. If idle_cnt reaches DEADLOCK_LIMIT, go to DEAD with deadlock=1.
- FIRE:
  - fire holds the one-hot value for exactly this cycle.
  - fire_count increments, wrapping modulo 2^CNT_W.
  - If SETTLE>0, load settle_cnt=SETTLE and go to SETTLE. Otherwise clear fire and go to ARB, or to IDLE if run=0.
- SETTLE: fire=0. Decrement settle_cnt. At 1, go to ARB (or IDLE if run=0).
- DEAD: deadlock=1.
  - If run=0, go to IDLE and clear deadlock.
  - Else if any en[t], go to ARB and clear deadlock. No firing happens in the same cycle.
- Firing cadence:
  - Latency from run sampled high (in IDLE) to fire asserted is 2 cycles.
  - Sustained period is SETTLE+2 cycles per firing.
- fire is never multi-hot and never asserted on consecutive cycles.
- run deasserted during FIRE or SETTLE: the firing and settle complete, then the block returns to IDLE. A fire is never truncated.
- inhibit and en_votes changes during FIRE or SETTLE are ignored until the next ARB.
- Reset asserted mid-FIRE: fire drops asynchronously, and the counter does not increment for that firing.
- Round-robin guarantee: a continuously enabled transition fires within N_TRANS firings.

Test Plan:
- Reset sequence: hold reset low 3 cycles with random inputs -> fire=0, busy=0, deadlock=0, fire_count=0, last_fire=0. Release reset with run=1 and nothing enabled -> busy=1, fire stays 0.
- Single firing: all FSMs vote t3, SETTLE=1, run rises at cycle 0 -> fire=9'h008 in cycle 2 only, fire_count=1, last_fire=3. It refires in cycle 5 if the votes persist.
- Round-robin: t1, t5 and t7 continuously enabled, SETTLE=1 -> fire order 1,5,7,1,5 at cycles 2,5,8,11,14. fire_count=5.
- Participation: PART_MASK excludes FSM0 from t6. FSM1 and FSM2 vote t6 while FSM0 does not -> t6 fires. For t0 (all participate), FSM0 and FSM1 vote without FSM2 -> t0 never fires. When FSM2 adds its vote, t0 fires on the next ARB.
- Deadlock: run=1, no enables, DEADLOCK_LIMIT=16 -> deadlock=1 after 16 ARB cycles and stays high. Enabling t2 -> deadlock clears next cycle, fire=9'h004 two cycles later.
- Abort and inhibit: during SETTLE of a t4 firing, drop run -> SETTLE completes, then IDLE with no further fire. With run=1, t4 enabled and inhibit[4]=1 -> no fire. Clearing inhibit -> t4 fires.
